// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor.
// Holds the control FSM state encoding.
package serial_subtractor_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

endpackage

// File: rtl/full_subtractor.sv
// Gate-level one-bit full subtractor: d = x - y - bin.
// Built from primitive gates so the cell maps directly to a library.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic xy;
    logic nx;
    logic nxy;
    logic t0;
    logic t1;

    xor g_xy  (xy, x, y);
    xor g_d   (d, xy, bin);
    not g_nx  (nx, x);
    and g_t0  (t0, nx, y);
    not g_nxy (nxy, xy);
    and g_t1  (t1, nxy, bin);
    or  g_bo  (bout, t0, t1);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell is reused with a registered borrow.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             cell_d;
    logic             cell_bo;
    logic             accept;
    logic [WIDTH-1:0] res_next;

    full_subtractor u_cell (
        .x    (sa_q[0]),
        .y    (sb_q[0]),
        .bin  (br_q),
        .d    (cell_d),
        .bout (cell_bo)
    );

    assign accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign res_next = {cell_d, res_q[WIDTH-1:1]};

    // Next-state: accept a request, step one bit, or retire the result
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (accept) begin
            state_d = S_SHIFT;
            sa_d    = a;
            sb_d    = b;
            br_d    = bin;
            cnt_d   = '0;
            busy_d  = 1'b1;
        end else if (state_q == S_SHIFT) begin
            sa_d  = sa_q >> 1;
            sb_d  = sb_q >> 1;
            res_d = res_next;
            br_d  = cell_bo;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
                state_d = S_DONE;
                diff_d  = res_next;
                bout_d  = cell_bo;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end
    end

    // State and datapath registers; reset discards any partial result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor.
// Reference results come from plain 9-bit arithmetic.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;

    logic       fx, fy, fz;
    logic       fd, fbo;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_diff = 8'h00;
    logic       exp_bout = 1'b0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    full_subtractor u_fs (
        .x    (fx),
        .y    (fy),
        .bin  (fz),
        .d    (fd),
        .bout (fbo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic txn(input logic [7:0] ta, input logic [7:0] tb_,
                       input logic tbin, input bit repulse);
        logic [8:0] r;
        r = {1'b0, ta} - {1'b0, tb_} - {8'd0, tbin};
        a = ta;
        b = tb_;
        bin = tbin;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        bin = 1'($urandom);
        for (int i = 1; i <= 8; i++) begin
            if (repulse && i == 3) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (i < 8) begin
                check("busy_shift", busy, 1);
                check("done_shift", done, 0);
                check("diff_hold", diff, exp_diff);
                check("bout_hold", bout, exp_bout);
            end else begin
                check("done_pulse", done, 1);
                check("busy_end", busy, 0);
                check("diff", diff, r[7:0]);
                check("bout", bout, r[8]);
                exp_diff = r[7:0];
                exp_bout = r[8];
            end
        end
    endtask

    initial begin
        int gap;
        bit seen;
        logic [2:0] code;
        int r;

        rst = 1'b1;
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        bin = 1'b0;
        fx = 1'b0;
        fy = 1'b0;
        fz = 1'b0;

        for (int c = 0; c < 8; c++) begin
            code = 3'(c);
            fx = code[2];
            fy = code[1];
            fz = code[0];
            #1;
            r = int'(fx) - int'(fy) - int'(fz);
            check("fs_d", fd, r & 1);
            check("fs_bout", fbo, (r < 0) ? 1 : 0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        txn(8'h5A, 8'h3C, 1'b0, 0);
        check("dir_5a_3c", {23'd0, bout, diff}, 32'h01E);
        txn(8'h00, 8'h01, 1'b0, 0);
        check("dir_00_01", {23'd0, bout, diff}, 32'h1FF);
        txn(8'h10, 8'h10, 1'b1, 0);
        check("dir_10_10_1", {23'd0, bout, diff}, 32'h1FF);

        txn(8'hC3, 8'h41, 1'b0, 1);
        check("repulse", {23'd0, bout, diff}, 32'h082);

        @(posedge clk);
        #1;
        check("idle_done", done, 0);

        start = 1'b1;
        a = 8'h77;
        b = 8'h11;
        bin = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_diff", diff, 0);
        check("mrst_bout", bout, 0);
        exp_diff = 8'h00;
        exp_bout = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1;
        end
        check("mrst_quiet", seen, 0);

        for (int n = 0; n < 1000; n++) begin
            txn(8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 3) == 0) begin
                gap = $urandom_range(1, 3);
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk);
                    #1;
                    check("gap_done", done, 0);
                    check("gap_busy", busy, 0);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
